// File: rtl/fp32_pkg.sv
// FP32 shared constants and pipeline payload types.
// Used by the multiplier post-processing stage and the rounder.
package fp32_pkg;

    localparam int EXP_W  = 8;
    localparam int MANT_W = 23;
    localparam int PROD_W = 48;
    localparam int SIG_W  = MANT_W + 1;

    localparam logic signed [9:0] FP32_BIAS = 10'sd127;
    localparam logic signed [9:0] EXP_MAX   = 10'sd255;
    localparam logic [31:0]       QNAN      = 32'h7FC0_0000;

    typedef struct packed {
        logic              sign;
        logic signed [9:0] exp;
        logic [SIG_W-1:0]  sig;
        logic              guard;
        logic              sticky;
        logic              zero;
        logic              inf;
        logic              nan;
    } s1_s2_t;

endpackage

// File: rtl/fp_round_rne.sv
// Combinational significand rounder: nearest-even or truncate.
// A rounding carry renormalises to 1.0 and bumps the exponent.
module fp_round_rne
    import fp32_pkg::*;
#(
    parameter bit ROUND_EN = 1'b1
) (
    input  logic [SIG_W-1:0]  sig,
    input  logic              guard,
    input  logic              sticky,
    input  logic signed [9:0] exp,
    output logic [SIG_W-1:0]  sig_out,
    output logic signed [9:0] exp_out,
    output logic              inexact
);

    logic          rnd;
    logic [SIG_W:0] sum;

    // Increment on guard when above half or on an odd tie.
    always_comb begin
        rnd     = ROUND_EN ? (guard & (sticky | sig[0])) : 1'b0;
        sum     = {1'b0, sig} + {{SIG_W{1'b0}}, rnd};
        inexact = guard | sticky;
        sig_out = sum[SIG_W-1:0];
        exp_out = exp;
        if (sum[SIG_W]) begin
            sig_out = {1'b1, {MANT_W{1'b0}}};
            exp_out = exp + 10'sd1;
        end
    end

endmodule

// File: rtl/fp_mul_round_norm.sv
// FP32 multiplier back end: normalise (S1), round and pack (S2).
// Two-deep valid/ready pipeline, one result per cycle.
module fp_mul_round_norm
    import fp32_pkg::*;
#(
    parameter bit ROUND_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [8:0]  in_exp_sum,
    input  logic [47:0] in_mant,
    input  logic        in_zero,
    input  logic        in_inf,
    input  logic        in_nan,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_overflow,
    output logic        out_underflow,
    output logic        out_inexact,
    output logic        out_invalid
);

    s1_s2_t            s1_d;
    s1_s2_t            s1_q;
    logic              s1_valid;
    logic              s2_valid;
    logic              s2_load;
    logic signed [9:0] exp_ext;

    logic [SIG_W-1:0]  r_sig;
    logic signed [9:0] r_exp;
    logic              r_inexact;
    logic              sig_unused;

    logic [31:0]       res;
    logic              ovf;
    logic              unf;
    logic              inx;
    logic              inv;

    assign s2_load   = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s2_load;
    assign out_valid = s2_valid;
    assign exp_ext   = $signed({1'b0, in_exp_sum});

    // Normalise the raw product to a 24-bit significand plus guard/sticky.
    always_comb begin
        s1_d      = '0;
        s1_d.sign = in_sign;
        s1_d.zero = in_zero;
        s1_d.inf  = in_inf;
        s1_d.nan  = in_nan;
        if (in_mant[PROD_W-1]) begin
            s1_d.sig    = in_mant[47:24];
            s1_d.guard  = in_mant[23];
            s1_d.sticky = |in_mant[22:0];
            s1_d.exp    = exp_ext - (FP32_BIAS - 10'sd1);
        end else begin
            s1_d.sig    = in_mant[46:23];
            s1_d.guard  = in_mant[22];
            s1_d.sticky = |in_mant[21:0];
            s1_d.exp    = exp_ext - FP32_BIAS;
        end
    end

    // S1 register: loads whenever the stage is empty or draining.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    fp_round_rne #(
        .ROUND_EN (ROUND_EN)
    ) u_round (
        .sig     (s1_q.sig),
        .guard   (s1_q.guard),
        .sticky  (s1_q.sticky),
        .exp     (s1_q.exp),
        .sig_out (r_sig),
        .exp_out (r_exp),
        .inexact (r_inexact)
    );

    // Hidden bit is implicit in the packed format.
    assign sig_unused = r_sig[SIG_W-1];

    // Range check the rounded value, then let special classes override.
    always_comb begin
        res = {s1_q.sign, r_exp[EXP_W-1:0], r_sig[MANT_W-1:0]};
        ovf = 1'b0;
        unf = 1'b0;
        inx = r_inexact;
        inv = 1'b0;
        if (r_exp >= EXP_MAX) begin
            res = {s1_q.sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            ovf = 1'b1;
            inx = 1'b1;
        end else if (r_exp <= 10'sd0) begin
            res = {s1_q.sign, 31'd0};
            unf = 1'b1;
            inx = 1'b1;
        end
        if (s1_q.nan) begin
            res = QNAN;
            ovf = 1'b0;
            unf = 1'b0;
            inx = 1'b0;
        end else if (s1_q.inf && s1_q.zero) begin
            res = QNAN;
            ovf = 1'b0;
            unf = 1'b0;
            inx = 1'b0;
            inv = 1'b1;
        end else if (s1_q.inf) begin
            res = {s1_q.sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
            ovf = 1'b0;
            unf = 1'b0;
            inx = 1'b0;
        end else if (s1_q.zero) begin
            res = {s1_q.sign, 31'd0};
            ovf = 1'b0;
            unf = 1'b0;
            inx = 1'b0;
        end
    end

    // S2 register: holds the packed result until downstream takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid      <= 1'b0;
            out_result    <= '0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
            out_invalid   <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_result    <= res;
                out_overflow  <= ovf;
                out_underflow <= unf;
                out_inexact   <= inx;
                out_invalid   <= inv;
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_round_norm.sv
// Directed bench for fp_mul_round_norm (RNE and truncating builds).
// Hand-computed vectors, back-pressure and asynchronous reset.
module tb_fp_mul_round_norm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sign = 1'b0;
    logic [8:0]  in_exp_sum = '0;
    logic [47:0] in_mant = '0;
    logic        in_zero = 1'b0;
    logic        in_inf = 1'b0;
    logic        in_nan = 1'b0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid;
    logic [31:0] out_result;
    logic        out_overflow, out_underflow, out_inexact, out_invalid;
    logic        t_in_ready, t_out_valid;
    logic [31:0] t_out_result;
    logic        t_overflow, t_underflow, t_inexact, t_invalid;
    logic [3:0]  flags, t_flags;

    int checks = 0;
    int errors = 0;

    assign flags   = {out_overflow, out_underflow, out_inexact, out_invalid};
    assign t_flags = {t_overflow, t_underflow, t_inexact, t_invalid};

    always #5 clk = ~clk;

    fp_mul_round_norm #(.ROUND_EN(1'b1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_sign       (in_sign),
        .in_exp_sum    (in_exp_sum),
        .in_mant       (in_mant),
        .in_zero       (in_zero),
        .in_inf        (in_inf),
        .in_nan        (in_nan),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_overflow  (out_overflow),
        .out_underflow (out_underflow),
        .out_inexact   (out_inexact),
        .out_invalid   (out_invalid)
    );

    fp_mul_round_norm #(.ROUND_EN(1'b0)) dut_t (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (t_in_ready),
        .in_sign       (in_sign),
        .in_exp_sum    (in_exp_sum),
        .in_mant       (in_mant),
        .in_zero       (in_zero),
        .in_inf        (in_inf),
        .in_nan        (in_nan),
        .out_valid     (t_out_valid),
        .out_ready     (out_ready),
        .out_result    (t_out_result),
        .out_overflow  (t_overflow),
        .out_underflow (t_underflow),
        .out_inexact   (t_inexact),
        .out_invalid   (t_invalid)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    typedef struct {
        string       tag;
        logic        s;
        logic [8:0]  e;
        logic [47:0] m;
        logic        z, i, n;
        logic [31:0] r;
        logic [3:0]  f;
        logic [31:0] rt;
        logic [3:0]  ft;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string tag, input logic s, input logic [8:0] e,
                       input logic [47:0] m, input logic z, input logic i,
                       input logic n, input logic [31:0] r, input logic [3:0] f,
                       input logic [31:0] rt, input logic [3:0] ft);
        vec_t v;
        v.tag = tag; v.s = s; v.e = e; v.m = m;
        v.z = z; v.i = i; v.n = n;
        v.r = r; v.f = f; v.rt = rt; v.ft = ft;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic s, input logic [8:0] e, input logic [47:0] m,
                         input logic z, input logic i, input logic n);
        in_sign = s; in_exp_sum = e; in_mant = m;
        in_zero = z; in_inf = i; in_nan = n;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        out_ready = 1'b1;
        drive(v.s, v.e, v.m, v.z, v.i, v.n);
        in_valid = 1'b1;
        #1 check({v.tag, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        #1 check({v.tag, "_lat1_valid"}, out_valid, 0);
        @(negedge clk);
        #1;
        check({v.tag, "_valid"}, out_valid, 1);
        check({v.tag, "_result"}, out_result, v.r);
        check({v.tag, "_flags"}, flags, v.f);
        check({v.tag, "_trunc_result"}, t_out_result, v.rt);
        check({v.tag, "_trunc_flags"}, t_flags, v.ft);
    endtask

    logic [47:0] bp_m [4];
    logic [8:0]  bp_e [4];
    logic        bp_s [4];
    logic [31:0] bp_r [4];

    initial begin
        int k;
        int nout;

        // flags order: overflow, underflow, inexact, invalid
        add("mul_1p5",   0, 254, 48'h9000_0000_0000, 0, 0, 0,
            32'h4010_0000, 4'b0000, 32'h4010_0000, 4'b0000);
        add("tie",       0, 254, 48'h6000_00C0_0000, 0, 0, 0,
            32'h3FC0_0002, 4'b0010, 32'h3FC0_0001, 4'b0010);
        add("sticky",    0, 254, 48'h4000_0100_0001, 0, 0, 0,
            32'h3F80_0002, 4'b0010, 32'h3F80_0002, 4'b0010);
        add("overflow",  0, 508, 48'h4000_0000_0000, 0, 0, 0,
            32'h7F80_0000, 4'b1010, 32'h7F80_0000, 4'b1010);
        add("underflow", 1, 2,   48'h4000_0000_0000, 0, 0, 0,
            32'h8000_0000, 4'b0110, 32'h8000_0000, 4'b0110);
        add("exp_zero",  0, 127, 48'h4000_0000_0000, 0, 0, 0,
            32'h0000_0000, 4'b0110, 32'h0000_0000, 4'b0110);
        add("min_norm",  0, 128, 48'h4000_0000_0000, 0, 0, 0,
            32'h0080_0000, 4'b0000, 32'h0080_0000, 4'b0000);
        add("max_exp",   0, 381, 48'h4000_0000_0000, 0, 0, 0,
            32'h7F00_0000, 4'b0000, 32'h7F00_0000, 4'b0000);
        add("rnd_ovf",   0, 381, 48'h7FFF_FFFF_FFFF, 0, 0, 0,
            32'h7F80_0000, 4'b1010, 32'h7F7F_FFFF, 4'b0010);
        add("bit47_carry", 0, 254, 48'hFFFF_FF80_0000, 0, 0, 0,
            32'h4080_0000, 4'b0010, 32'h407F_FFFF, 4'b0010);
        add("inf_x_zero", 0, 0,  48'h0, 1, 1, 0,
            32'h7FC0_0000, 4'b0001, 32'h7FC0_0000, 4'b0001);
        add("nan_prio",  1, 300, 48'h9000_0000_0000, 1, 1, 1,
            32'h7FC0_0000, 4'b0000, 32'h7FC0_0000, 4'b0000);
        add("neg_inf",   1, 508, 48'h9000_0000_0000, 0, 1, 0,
            32'hFF80_0000, 4'b0000, 32'hFF80_0000, 4'b0000);
        add("neg_zero",  1, 254, 48'h9000_0000_0000, 1, 0, 0,
            32'h8000_0000, 4'b0000, 32'h8000_0000, 4'b0000);

        bp_s[0] = 0; bp_e[0] = 254; bp_m[0] = 48'h4000_0000_0000; bp_r[0] = 32'h3F80_0000;
        bp_s[1] = 0; bp_e[1] = 254; bp_m[1] = 48'h9000_0000_0000; bp_r[1] = 32'h4010_0000;
        bp_s[2] = 0; bp_e[2] = 255; bp_m[2] = 48'h4000_0000_0000; bp_r[2] = 32'h4000_0000;
        bp_s[3] = 1; bp_e[3] = 254; bp_m[3] = 48'h6000_0000_0000; bp_r[3] = 32'hBFC0_0000;

        // Reset state
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_result", out_result, 0);
        check("rst_flags", flags, 0);
        rst_n = 1'b1;
        #1 check("rst_in_ready", in_ready, 1);

        foreach (vecs[j]) run_vec(vecs[j]);

        // Back-pressure: out_ready low for the first 5 cycles
        k = 0;
        nout = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            if (k < 4) begin
                drive(bp_s[k], bp_e[k], bp_m[k], 0, 0, 0);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc == 1) check("bp_in_ready_2nd", in_ready, 1);
            if (cyc == 2) check("bp_in_ready_low", in_ready, 0);
            if (out_valid) begin
                if (nout < 4)
                    check($sformatf("bp_out%0d_c%0d", nout, cyc), out_result, bp_r[nout]);
                else
                    check("bp_extra_out", out_valid, 0);
                if (out_ready) nout++;
            end
            if (in_valid && in_ready) k++;
        end
        check("bp_accepts", k, 4);
        check("bp_outputs", nout, 4);

        // Asynchronous reset while the pipe holds data
        @(negedge clk);
        out_ready = 1'b0;
        drive(0, 254, 48'h9000_0000_0000, 0, 0, 0);
        in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #1 check("mid_valid_before", out_valid, 1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_result", out_result, 0);
        check("mid_rst_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vecs[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
